mvu_icb_sram_tgt: RTL and testbench



---
 rtl/mvu_icb_pkg.sv | 15 +
 rtl/mvu_icb_sram_tgt_if.sv | 35 +++
 rtl/mvu_icb_rsp_fifo.sv | 49 ++++
 rtl/mvu_icb_sram_tgt.sv | 119 +++++++++++
 tb/tb_mvu_icb_sram_tgt.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mvu_icb_pkg.sv
// mvu_icb_pkg: shared widths, response bundle and buffer depth
// for the MVU-side ICB SRAM target.
package mvu_icb_pkg;

  localparam int DEF_AW     = 32;
  localparam int DEF_DW     = 32;
  localparam int DEF_MEM_AW = 12;
  localparam int RSP_DEPTH  = 2;

  typedef struct packed {
    logic              err;
    logic [DEF_DW-1:0] rdata;
  } icb_rsp_t;

endpackage

// File: rtl/mvu_icb_sram_tgt_if.sv
// mvu_icb_sram_tgt_if: ICB command/response channel bundle.
// master = initiator (drives cmd, rsp_ready); slave = target.
interface mvu_icb_sram_tgt_if #(
  parameter int AW = 32,
  parameter int DW = 32
);

  logic          icb_cmd_valid;
  logic          icb_cmd_ready;
  logic [AW-1:0] icb_cmd_addr;
  logic          icb_cmd_read;
  logic [DW-1:0] icb_cmd_wdata;
  logic [DW/8-1:0] icb_cmd_wmask;
  logic          icb_rsp_valid;
  logic          icb_rsp_ready;
  logic          icb_rsp_err;
  logic [DW-1:0] icb_rsp_rdata;

  modport master (
    output icb_cmd_valid, icb_cmd_addr,
    output icb_cmd_read, icb_cmd_wdata,
    output icb_cmd_wmask, icb_rsp_ready,
    input  icb_cmd_ready, icb_rsp_valid,
    input  icb_rsp_err, icb_rsp_rdata
  );

  modport slave (
    input  icb_cmd_valid, icb_cmd_addr,
    input  icb_cmd_read, icb_cmd_wdata,
    input  icb_cmd_wmask, icb_rsp_ready,
    output icb_cmd_ready, icb_rsp_valid,
    output icb_rsp_err, icb_rsp_rdata
  );

endinterface

// File: rtl/mvu_icb_rsp_fifo.sv
// mvu_icb_rsp_fifo: 2-entry response FIFO.
// Ports: clk, rst, push/wdata, pop/rdata, full, empty, count.
module mvu_icb_rsp_fifo
  import mvu_icb_pkg::*;
#(
  parameter type T = icb_rsp_t
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  T           wdata,
  input  logic       pop,
  output T           rdata,
  output logic       full,
  output logic       empty,
  output logic [1:0] count
);

  T     mem [RSP_DEPTH];
  logic wr_ptr;
  logic rd_ptr;
  logic do_pop;

  assign do_pop = pop && !empty;
  assign empty  = (count == 2'd0);
  assign full   = (count == 2'd2);
  assign rdata  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push)   wr_ptr <= ~wr_ptr;
      if (do_pop) rd_ptr <= ~rd_ptr;
      unique case ({push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/mvu_icb_sram_tgt.sv
// mvu_icb_sram_tgt: ICB target on a 1-cycle-latency SRAM; icb (slave
// modport), sram_* port. MVU_ICB_ADDR_CHECK_EN enables window check.
module mvu_icb_sram_tgt
  import mvu_icb_pkg::*;
#(
  parameter int          AW        = DEF_AW,
  parameter int          DW        = DEF_DW,
  parameter int          MEM_AW    = DEF_MEM_AW,
  parameter logic [AW-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst,
  mvu_icb_sram_tgt_if.slave icb,
  output logic              sram_cs,
  output logic              sram_we,
  output logic [MEM_AW-1:0] sram_addr,
  output logic [DW/8-1:0]   sram_wem,
  output logic [DW-1:0]     sram_din,
  input  logic [DW-1:0]     sram_dout
);

  typedef struct packed {
    logic          err;
    logic [DW-1:0] rdata;
  } rsp_t;

  logic       accept;
  logic       err;
  logic       p1_valid;
  logic       p1_read;
  logic       p1_err;
  rsp_t       p1_rsp;
  rsp_t       head;
  rsp_t       rsp_sel;
  logic       rsp_valid;
  logic       rsp_hs;
  logic       push;
  logic       pop;
  logic       f_full;
  logic       f_empty;
  logic [1:0] f_count;
  logic [1:0] outstanding;

  assign outstanding = {1'b0, p1_valid} + f_count;
  assign icb.icb_cmd_ready = !rst && (outstanding < 2'd2);
  assign accept = icb.icb_cmd_valid && icb.icb_cmd_ready;

`ifdef MVU_ICB_ADDR_CHECK_EN
  // Window is aligned to its size, so only the upper bits matter.
  assign err = icb.icb_cmd_addr[AW-1:MEM_AW+2]
            != BASE_ADDR[AW-1:MEM_AW+2];
  logic unused_bits;
  assign unused_bits = ^{icb.icb_cmd_addr[1:0], f_full};
`else
  assign err = 1'b0;
  logic unused_bits;
  assign unused_bits = ^{icb.icb_cmd_addr[1:0], f_full,
                         icb.icb_cmd_addr[AW-1:MEM_AW+2],
                         BASE_ADDR};
`endif

  assign sram_cs   = accept && !err;
  assign sram_we   = !icb.icb_cmd_read;
  assign sram_addr = icb.icb_cmd_addr[MEM_AW+1:2];
  assign sram_wem  = icb.icb_cmd_wmask;
  assign sram_din  = icb.icb_cmd_wdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      p1_valid <= 1'b0;
      p1_read  <= 1'b0;
      p1_err   <= 1'b0;
    end else begin
      p1_valid <= accept;
      p1_read  <= icb.icb_cmd_read;
      p1_err   <= err;
    end
  end

  always_comb begin
    p1_rsp.err   = p1_valid && p1_err;
    p1_rsp.rdata = '0;
    if (p1_valid && p1_read && !p1_err)
      p1_rsp.rdata = sram_dout;
  end

  // Older buffered responses always go first; p1 bypasses
  // only when nothing is queued ahead of it.
  always_comb begin
    rsp_valid = p1_valid;
    rsp_sel   = p1_rsp;
    if (!f_empty) begin
      rsp_valid = 1'b1;
      rsp_sel   = head;
    end
    if (rst) rsp_valid = 1'b0;
  end

  assign rsp_hs = rsp_valid && icb.icb_rsp_ready;
  assign push   = p1_valid && !(f_empty && rsp_hs);
  assign pop    = !f_empty && rsp_hs;

  mvu_icb_rsp_fifo #(.T(rsp_t)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (p1_rsp),
    .pop   (pop),
    .rdata (head),
    .full  (f_full),
    .empty (f_empty),
    .count (f_count)
  );

  assign icb.icb_rsp_valid = rsp_valid;
  assign icb.icb_rsp_err   = rsp_sel.err;
  assign icb.icb_rsp_rdata = rsp_sel.rdata;

endmodule

// File: tb/tb_mvu_icb_sram_tgt.sv
// tb_mvu_icb_sram_tgt: directed self-checking bench for
// mvu_icb_sram_tgt with a behavioural 1-cycle SRAM.
module tb_mvu_icb_sram_tgt;

  logic        clk;
  logic        rst;
  logic        sram_cs;
  logic        sram_we;
  logic [11:0] sram_addr;
  logic [3:0]  sram_wem;
  logic [31:0] sram_din;
  logic [31:0] sram_dout;
  logic [31:0] mem [0:4095];

  int n_asrt = 0;
  int n_fail = 0;

  mvu_icb_sram_tgt_if #(.AW(32), .DW(32)) icb ();

  mvu_icb_sram_tgt #(
    .AW(32), .DW(32), .MEM_AW(12), .BASE_ADDR(32'h0)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .icb       (icb),
    .sram_cs   (sram_cs),
    .sram_we   (sram_we),
    .sram_addr (sram_addr),
    .sram_wem  (sram_wem),
    .sram_din  (sram_din),
    .sram_dout (sram_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (sram_cs) begin
      if (sram_we) begin
        for (int b = 0; b < 4; b++)
          if (sram_wem[b])
            mem[sram_addr][8*b +: 8] <= sram_din[8*b +: 8];
      end else begin
        sram_dout <= mem[sram_addr];
      end
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_cmd(input string tag, input logic rd,
                        input logic [31:0] a,
                        input logic [31:0] wd,
                        input logic [3:0] m);
    icb.icb_cmd_valid = 1'b1;
    icb.icb_cmd_read  = rd;
    icb.icb_cmd_addr  = a;
    icb.icb_cmd_wdata = wd;
    icb.icb_cmd_wmask = m;
    #1 chk({tag, "_rdy"}, 32'(icb.icb_cmd_ready), 32'd1);
    step();
    icb.icb_cmd_valid = 1'b0;
  endtask

  task automatic exp_rsp(input string tag,
                         input logic [31:0] rd,
                         input logic e);
    #1;
    chk({tag, "_vld"}, 32'(icb.icb_rsp_valid), 32'd1);
    chk({tag, "_dat"}, icb.icb_rsp_rdata, rd);
    chk({tag, "_err"}, 32'(icb.icb_rsp_err), 32'(e));
    step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    icb.icb_cmd_valid = 1'b0;
    icb.icb_cmd_read  = 1'b0;
    icb.icb_cmd_addr  = '0;
    icb.icb_cmd_wdata = '0;
    icb.icb_cmd_wmask = '0;
    icb.icb_rsp_ready = 1'b0;
    step(); step();
    chk("rst_cmd_ready", 32'(icb.icb_cmd_ready), 0);
    chk("rst_rsp_valid", 32'(icb.icb_rsp_valid), 0);
    chk("rst_rsp_err", 32'(icb.icb_rsp_err), 0);
    chk("rst_rsp_rdata", icb.icb_rsp_rdata, 0);
    chk("rst_sram_cs", 32'(sram_cs), 0);
    rst = 1'b0;
    #1 chk("post_rst_ready", 32'(icb.icb_cmd_ready), 1);

    // write then read, rsp_ready high
    icb.icb_rsp_ready = 1'b1;
    icb.icb_cmd_valid = 1'b1;
    icb.icb_cmd_read  = 1'b0;
    icb.icb_cmd_addr  = 32'h10;
    icb.icb_cmd_wdata = 32'hDEADBEEF;
    icb.icb_cmd_wmask = 4'hF;
    #1;
    chk("wr_cs", 32'(sram_cs), 1);
    chk("wr_we", 32'(sram_we), 1);
    chk("wr_addr", 32'(sram_addr), 32'h4);
    chk("wr_rsp_none", 32'(icb.icb_rsp_valid), 0);
    step();
    icb.icb_cmd_read = 1'b1;
    #1;
    chk("wr_rsp_vld", 32'(icb.icb_rsp_valid), 1);
    chk("wr_rsp_dat", icb.icb_rsp_rdata, 0);
    chk("wr_rsp_err", 32'(icb.icb_rsp_err), 0);
    chk("rd_cs", 32'(sram_cs), 1);
    chk("rd_we", 32'(sram_we), 0);
    step();
    icb.icb_cmd_valid = 1'b0;
    #1;
    chk("rd_rsp_vld", 32'(icb.icb_rsp_valid), 1);
    chk("rd_rsp_dat", icb.icb_rsp_rdata, 32'hDEADBEEF);
    step();
    chk("rd_rsp_gone", 32'(icb.icb_rsp_valid), 0);

    // zero-mask write still answers, data untouched
    do_cmd("wm0", 1'b0, 32'h10, 32'h0BAD0BAD, 4'h0);
    exp_rsp("wm0_rsp", 32'h0, 1'b0);
    do_cmd("wm0_rd", 1'b1, 32'h10, 32'h0, 4'h0);
    exp_rsp("wm0_rd_rsp", 32'hDEADBEEF, 1'b0);

    // byte-mask write
    do_cmd("bm_full", 1'b0, 32'h20, 32'hFFFFFFFF, 4'hF);
    exp_rsp("bm_full_rsp", 32'h0, 1'b0);
    do_cmd("bm_part", 1'b0, 32'h20, 32'h11223344, 4'b0101);
    exp_rsp("bm_part_rsp", 32'h0, 1'b0);
    do_cmd("bm_rd", 1'b1, 32'h23, 32'h0, 4'h0);
    exp_rsp("bm_rd_rsp", 32'hFF22FF44, 1'b0);

    // preload 8 words
    for (int i = 0; i < 8; i++) begin
      do_cmd("pre", 1'b0, 32'h100 + 32'(4 * i),
             32'hA5000000 | 32'(i), 4'hF);
      exp_rsp("pre_rsp", 32'h0, 1'b0);
    end

    // back-to-back reads, no bubbles
    icb.icb_cmd_read = 1'b1;
    for (int i = 0; i < 8; i++) begin
      icb.icb_cmd_valid = 1'b1;
      icb.icb_cmd_addr  = 32'h100 + 32'(4 * i);
      #1;
      chk("b2b_rdy", 32'(icb.icb_cmd_ready), 1);
      if (i > 0) begin
        chk("b2b_vld", 32'(icb.icb_rsp_valid), 1);
        chk("b2b_dat", icb.icb_rsp_rdata,
            32'hA5000000 | 32'(i - 1));
      end else begin
        chk("b2b_idle", 32'(icb.icb_rsp_valid), 0);
      end
      step();
    end
    icb.icb_cmd_valid = 1'b0;
    #1;
    chk("b2b_last_vld", 32'(icb.icb_rsp_valid), 1);
    chk("b2b_last_dat", icb.icb_rsp_rdata, 32'hA5000007);
    step();
    chk("b2b_done", 32'(icb.icb_rsp_valid), 0);

    // backpressure: 2 accepted, held response, drain
    icb.icb_rsp_ready = 1'b0;
    icb.icb_cmd_valid = 1'b1;
    icb.icb_cmd_addr  = 32'h100;
    #1 chk("bp_c0_rdy", 32'(icb.icb_cmd_ready), 1);
    step();
    icb.icb_cmd_addr = 32'h104;
    #1;
    chk("bp_c1_rdy", 32'(icb.icb_cmd_ready), 1);
    chk("bp_c1_vld", 32'(icb.icb_rsp_valid), 1);
    chk("bp_c1_dat", icb.icb_rsp_rdata, 32'hA5000000);
    step();
    icb.icb_cmd_addr = 32'h108;
    #1;
    chk("bp_c2_rdy", 32'(icb.icb_cmd_ready), 0);
    chk("bp_c2_dat", icb.icb_rsp_rdata, 32'hA5000000);
    step();
    chk("bp_c3_rdy", 32'(icb.icb_cmd_ready), 0);
    chk("bp_hold_vld", 32'(icb.icb_rsp_valid), 1);
    chk("bp_hold_dat", icb.icb_rsp_rdata, 32'hA5000000);
    step();
    icb.icb_rsp_ready = 1'b1;
    #1;
    chk("bp_r0_dat", icb.icb_rsp_rdata, 32'hA5000000);
    chk("bp_r0_rdy", 32'(icb.icb_cmd_ready), 0);
    step();
    chk("bp_r1_dat", icb.icb_rsp_rdata, 32'hA5000001);
    chk("bp_r1_rdy", 32'(icb.icb_cmd_ready), 1);
    step();
    icb.icb_cmd_addr = 32'h10C;
    #1;
    chk("bp_r2_dat", icb.icb_rsp_rdata, 32'hA5000002);
    chk("bp_r2_rdy", 32'(icb.icb_cmd_ready), 1);
    step();
    icb.icb_cmd_valid = 1'b0;
    #1 chk("bp_r3_dat", icb.icb_rsp_rdata, 32'hA5000003);
    step();
    chk("bp_done", 32'(icb.icb_rsp_valid), 0);

    // out-of-window read
    do_cmd("w0", 1'b0, 32'h0, 32'hCAFEF00D, 4'hF);
    exp_rsp("w0_rsp", 32'h0, 1'b0);
    icb.icb_cmd_valid = 1'b1;
    icb.icb_cmd_read  = 1'b1;
    icb.icb_cmd_addr  = 32'h4000;
    #1;
    chk("oow_rdy", 32'(icb.icb_cmd_ready), 1);
`ifdef MVU_ICB_ADDR_CHECK_EN
    chk("oow_cs", 32'(sram_cs), 0);
    step();
    icb.icb_cmd_valid = 1'b0;
    exp_rsp("oow_rsp", 32'h0, 1'b1);
`else
    chk("oow_cs", 32'(sram_cs), 1);
    chk("oow_addr", 32'(sram_addr), 0);
    step();
    icb.icb_cmd_valid = 1'b0;
    exp_rsp("oow_rsp", 32'hCAFEF00D, 1'b0);
`endif

    // reset with 2 buffered responses
    icb.icb_rsp_ready = 1'b0;
    icb.icb_cmd_valid = 1'b1;
    icb.icb_cmd_addr  = 32'h110;
    step();
    icb.icb_cmd_addr = 32'h114;
    step();
    icb.icb_cmd_valid = 1'b0;
    #1 chk("mr_full_rdy", 32'(icb.icb_cmd_ready), 0);
    rst = 1'b1;
    #1;
    chk("mr_rst_rdy", 32'(icb.icb_cmd_ready), 0);
    chk("mr_rst_vld", 32'(icb.icb_rsp_valid), 0);
    step();
    rst = 1'b0;
    #1;
    chk("mr_post_vld", 32'(icb.icb_rsp_valid), 0);
    chk("mr_post_rdy", 32'(icb.icb_cmd_ready), 1);
    chk("mr_post_dat", icb.icb_rsp_rdata, 0);
    icb.icb_rsp_ready = 1'b1;
    step();
    chk("mr_stale1", 32'(icb.icb_rsp_valid), 0);
    step();
    chk("mr_stale2", 32'(icb.icb_rsp_valid), 0);
    do_cmd("mr_rd", 1'b1, 32'h114, 32'h0, 4'h0);
    exp_rsp("mr_rd_rsp", 32'hA5000005, 1'b0);
    chk("mr_end", 32'(icb.icb_rsp_valid), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_asrt, n_fail);
    $finish;
  end

endmodule
